// File: rtl/mem_addr_burst_reg_pkg.sv
// Shared types and constants for the burst-capable memory address register.
// Provides the FSM state enum, default widths and the select-index width helper.
package mem_addr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_e;

    localparam int ADDR_W_DEF = 22;
    localparam int LEN_W_DEF  = 8;

    // A single bus still needs a one-bit index to address the bus array.
    function automatic int sel_width(input int numBus);
        if (numBus <= 2) begin
            return 1;
        end
        return $clog2(numBus);
    endfunction

endpackage

// File: rtl/mem_addr_burst_reg_burst_len_counter.sv
// Burst beat counter: loads the programmed length, counts down on each beat
// and flags the final beat (remaining == 1).
module burst_len_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [LEN_W-1:0] remaining_q;
    logic [LEN_W-1:0] remaining_d;

    always_comb begin
        remaining_d = remaining_q;
        if (load_i) begin
            remaining_d = len_i;
        end else if (dec_i && (remaining_q != '0)) begin
            remaining_d = remaining_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remaining_q <= '0;
        end else begin
            remaining_q <= remaining_d;
        end
    end

    assign last_o = (remaining_q == LEN_W'(1));

endmodule

// File: rtl/mem_addr_burst_reg.sv
// Memory address register with fixed-priority bus load and auto-increment bursts.
// Optional sticky address-overflow flag enabled by defining MEM_ADDR_OVF_DETECT_EN.
module mem_addr_burst_reg
    import mem_addr_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NUM_BUS = 2,
    parameter int LEN_W   = LEN_W_DEF,
    parameter int STRIDE  = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_BUS*ADDR_W-1:0] bus_data,
    input  logic [NUM_BUS-1:0]        bus_in,
    input  logic                      burst_start,
    input  logic [LEN_W-1:0]          burst_len,
    input  logic                      burst_abort,
    input  logic                      mem_ack,
    output logic [ADDR_W-1:0]         mem_address,
    output logic                      mem_valid,
    output logic                      busy,
    output logic                      burst_done,
    output logic                      addr_ovf
);

    localparam int SEL_W = sel_width(NUM_BUS);

    burst_state_e      state_q;
    burst_state_e      state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              done_q;
    logic              done_d;

    logic [ADDR_W-1:0] busArr [NUM_BUS];
    logic [SEL_W-1:0]  selIdx;
    logic              loadHit;
    logic [ADDR_W-1:0] loadAddr;
    logic [ADDR_W-1:0] addrInc;

    logic              cntLoad;
    logic              cntDec;
    logic              cntLast;

    always_comb begin
        for (int i = 0; i < NUM_BUS; i++) begin
            busArr[i] = bus_data[i*ADDR_W +: ADDR_W];
        end
    end

    // Scan from the top so the lowest set strobe is the last to win.
    always_comb begin
        loadHit = |bus_in;
        selIdx  = '0;
        for (int i = NUM_BUS - 1; i >= 0; i--) begin
            if (bus_in[i]) begin
                selIdx = SEL_W'(i);
            end
        end
        loadAddr = busArr[selIdx];
    end

`ifdef MEM_ADDR_OVF_DETECT_EN
    localparam logic [ADDR_W:0] STEP_EXT = (ADDR_W + 1)'(STRIDE);

    logic [ADDR_W:0] incrSum;
    logic            ovf_q;

    assign incrSum = {1'b0, addr_q} + STEP_EXT;
    assign addrInc = incrSum[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == IDLE) && (loadHit || burst_start)) begin
            ovf_q <= 1'b0;
        end else if ((state_q == BURST) && !burst_abort && mem_ack && incrSum[ADDR_W]) begin
            ovf_q <= 1'b1;
        end
    end

    assign addr_ovf = ovf_q;
`else
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

    assign addrInc  = addr_q + STEP;
    assign addr_ovf = 1'b0;
`endif

    // Abort is checked before ack so an aborted beat never advances the address.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        cntLoad = 1'b0;
        cntDec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (loadHit) begin
                    addr_d = loadAddr;
                end
                if (burst_start && (burst_len != '0)) begin
                    state_d = BURST;
                    cntLoad = 1'b1;
                end
            end
            BURST: begin
                if (burst_abort) begin
                    state_d = IDLE;
                end else if (mem_ack) begin
                    addr_d = addrInc;
                    cntDec = 1'b1;
                    if (cntLast) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
        end
    end

    burst_len_counter #(
        .LEN_W (LEN_W)
    ) u_len_counter (
        .clk    (clk),
        .rst    (rst),
        .load_i (cntLoad),
        .len_i  (burst_len),
        .dec_i  (cntDec),
        .last_o (cntLast)
    );

    assign mem_address = addr_q;
    assign mem_valid   = (state_q == BURST);
    assign busy        = (state_q == BURST);
    assign burst_done  = done_q;

endmodule

// File: tb/tb_mem_addr_burst_reg.sv
// Self-checking bench for mem_addr_burst_reg with a queue of expected beat addresses.
// Overflow expectations follow MEM_ADDR_OVF_DETECT_EN when it is defined.
module tb_mem_addr_burst_reg;

    localparam int AW = 22;
    localparam int NB = 2;
    localparam int LW = 8;

    logic          clk;
    logic          rst;
    logic [NB*AW-1:0] bus_data;
    logic [NB-1:0] bus_in;
    logic          burst_start;
    logic [LW-1:0] burst_len;
    logic          burst_abort;
    logic          mem_ack;
    logic [AW-1:0] mem_address;
    logic          mem_valid;
    logic          busy;
    logic          burst_done;
    logic          addr_ovf;

    int assertCount = 0;
    int failCount   = 0;
    logic [AW-1:0] expQ [$];
    logic [AW-1:0] expAddr;

`ifdef MEM_ADDR_OVF_DETECT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    mem_addr_burst_reg dut (
        .clk         (clk),
        .rst         (rst),
        .bus_data    (bus_data),
        .bus_in      (bus_in),
        .burst_start (burst_start),
        .burst_len   (burst_len),
        .burst_abort (burst_abort),
        .mem_ack     (mem_ack),
        .mem_address (mem_address),
        .mem_valid   (mem_valid),
        .busy        (busy),
        .burst_done  (burst_done),
        .addr_ovf    (addr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus_in      = '0;
        burst_start = 1'b0;
        burst_len   = '0;
        burst_abort = 1'b0;
        mem_ack     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idleInputs();
        bus_data = '0;
        applyStimulus();
        applyStimulus();
        assertCount++;
        if (mem_address !== '0) begin failCount++; $display("[TB] FAIL reset_addr: got %h expected %h", mem_address, 22'h0); end
        assertCount++;
        if (mem_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_valid: got %b expected 0", mem_valid); end
        assertCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        assertCount++;
        if (burst_done !== 1'b0) begin failCount++; $display("[TB] FAIL reset_done: got %b expected 0", burst_done); end
        assertCount++;
        if (addr_ovf !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ovf: got %b expected 0", addr_ovf); end
        rst = 1'b0;
    endtask

    task automatic test_priority();
        bus_data = {22'h3F_FFFF, 22'h00_1234};
        bus_in   = 2'b11;
        applyStimulus();
        assertCount++;
        if (mem_address !== 22'h00_1234) begin failCount++; $display("[TB] FAIL prio_both: got %h expected %h", mem_address, 22'h00_1234); end
        bus_in = 2'b10;
        applyStimulus();
        assertCount++;
        if (mem_address !== 22'h3F_FFFF) begin failCount++; $display("[TB] FAIL prio_bus1: got %h expected %h", mem_address, 22'h3F_FFFF); end
        bus_in = 2'b00;
        bus_data = {22'h0, 22'h2A};
        applyStimulus();
        assertCount++;
        if (mem_address !== 22'h3F_FFFF) begin failCount++; $display("[TB] FAIL prio_hold: got %h expected %h", mem_address, 22'h3F_FFFF); end
    endtask

    task automatic test_burst();
        bus_data    = {22'h000100, 22'h0};
        bus_in      = 2'b10;
        burst_start = 1'b1;
        burst_len   = 8'd4;
        for (int i = 0; i < 4; i++) expQ.push_back(22'h000100 + AW'(i));
        applyStimulus();
        idleInputs();
        assertCount++;
        if (busy !== 1'b1 || mem_valid !== 1'b1) begin failCount++; $display("[TB] FAIL burst_busy: got %b/%b expected 1/1", busy, mem_valid); end
        for (int i = 0; i < 4; i++) begin
            mem_ack = 1'b1;
            expAddr = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            assertCount++;
            if (mem_address !== expAddr) begin failCount++; $display("[TB] FAIL burst_beat%0d: got %h expected %h", i, mem_address, expAddr); end
            applyStimulus();
            assertCount++;
            if (burst_done !== (i == 3)) begin failCount++; $display("[TB] FAIL burst_done%0d: got %b expected %b", i, burst_done, (i == 3)); end
        end
        mem_ack = 1'b0;
        assertCount++;
        if (mem_address !== 22'h000104) begin failCount++; $display("[TB] FAIL burst_final: got %h expected %h", mem_address, 22'h000104); end
        assertCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL burst_idle: got %b expected 0", busy); end
        applyStimulus();
        assertCount++;
        if (burst_done !== 1'b0) begin failCount++; $display("[TB] FAIL burst_pulse: got %b expected 0", burst_done); end
    endtask

    task automatic test_stall();
        logic [AW-1:0] model;
        logic ackNow;
        bus_data    = {22'h0, 22'h000020};
        bus_in      = 2'b01;
        burst_start = 1'b1;
        burst_len   = 8'd3;
        applyStimulus();
        idleInputs();
        model = 22'h000020;
        for (int c = 1; c <= 5; c++) begin
            ackNow = (c == 1) || (c == 4) || (c == 5);
            mem_ack = ackNow;
            expQ.push_back(model);
            expAddr = expQ.pop_front();
            assertCount++;
            if (mem_address !== expAddr) begin failCount++; $display("[TB] FAIL stall_addr%0d: got %h expected %h", c, mem_address, expAddr); end
            applyStimulus();
            if (ackNow) model = model + 1'b1;
            assertCount++;
            if (burst_done !== (c == 5)) begin failCount++; $display("[TB] FAIL stall_done%0d: got %b expected %b", c, burst_done, (c == 5)); end
        end
        mem_ack = 1'b0;
        assertCount++;
        if (mem_address !== 22'h000023 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL stall_end: got %h/%b expected %h/0", mem_address, busy, 22'h000023); end
    endtask

    task automatic test_ignore_busy();
        bus_data    = {22'h000040, 22'h0};
        bus_in      = 2'b10;
        burst_start = 1'b1;
        burst_len   = 8'd3;
        for (int i = 0; i < 3; i++) expQ.push_back(22'h000040 + AW'(i));
        applyStimulus();
        bus_data    = {22'h000040, 22'h3FFF00};
        bus_in      = 2'b01;
        burst_start = 1'b1;
        burst_len   = 8'd7;
        for (int i = 0; i < 3; i++) begin
            mem_ack = 1'b1;
            expAddr = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            assertCount++;
            if (mem_address !== expAddr) begin failCount++; $display("[TB] FAIL busy_beat%0d: got %h expected %h", i, mem_address, expAddr); end
            if (i == 2) begin
                bus_in      = 2'b00;
                burst_start = 1'b0;
            end
            applyStimulus();
        end
        mem_ack = 1'b0;
        assertCount++;
        if (burst_done !== 1'b1) begin failCount++; $display("[TB] FAIL busy_done: got %b expected 1", burst_done); end
        assertCount++;
        if (mem_address !== 22'h000043) begin failCount++; $display("[TB] FAIL busy_final: got %h expected %h", mem_address, 22'h000043); end
        applyStimulus();
        assertCount++;
        if (busy !== 1'b0) begin failCount++; $display("[TB] FAIL busy_norestart: got %b expected 0", busy); end
    endtask

    task automatic test_abort_wrap();
        bus_data    = {22'h0, 22'h3F_FFFE};
        bus_in      = 2'b01;
        burst_start = 1'b1;
        burst_len   = 8'd4;
        expQ.push_back(22'h3F_FFFE);
        expQ.push_back(22'h3F_FFFF);
        expQ.push_back(22'h00_0000);
        applyStimulus();
        idleInputs();
        for (int i = 0; i < 2; i++) begin
            mem_ack = 1'b1;
            expAddr = (expQ.size() > 0) ? expQ.pop_front() : 'x;
            assertCount++;
            if (mem_address !== expAddr) begin failCount++; $display("[TB] FAIL wrap_beat%0d: got %h expected %h", i, mem_address, expAddr); end
            applyStimulus();
        end
        expAddr = (expQ.size() > 0) ? expQ.pop_front() : 'x;
        assertCount++;
        if (mem_address !== expAddr) begin failCount++; $display("[TB] FAIL wrap_zero: got %h expected %h", mem_address, expAddr); end
        burst_abort = 1'b1;
        mem_ack     = 1'b1;
        applyStimulus();
        idleInputs();
        assertCount++;
        if (busy !== 1'b0 || mem_address !== 22'h0 || burst_done !== 1'b0) begin
            failCount++; $display("[TB] FAIL abort: got busy=%b addr=%h done=%b expected 0/%h/0", busy, mem_address, burst_done, 22'h0);
        end
        assertCount++;
        if (addr_ovf !== OVF_EXP) begin failCount++; $display("[TB] FAIL ovf_set: got %b expected %b", addr_ovf, OVF_EXP); end
        applyStimulus();
        assertCount++;
        if (addr_ovf !== OVF_EXP) begin failCount++; $display("[TB] FAIL ovf_sticky: got %b expected %b", addr_ovf, OVF_EXP); end
        bus_data = {22'h000055, 22'h0};
        bus_in   = 2'b10;
        applyStimulus();
        bus_in = 2'b00;
        assertCount++;
        if (addr_ovf !== 1'b0 || mem_address !== 22'h000055) begin failCount++; $display("[TB] FAIL ovf_clear: got %b/%h expected 0/%h", addr_ovf, mem_address, 22'h000055); end
    endtask

    task automatic test_zero_and_reset();
        burst_start = 1'b1;
        burst_len   = 8'd0;
        applyStimulus();
        assertCount++;
        if (busy !== 1'b0 || burst_done !== 1'b0 || mem_address !== 22'h000055) begin
            failCount++; $display("[TB] FAIL zero_len: got busy=%b done=%b addr=%h expected 0/0/%h", busy, burst_done, mem_address, 22'h000055);
        end
        bus_data = {22'h0, 22'h000077};
        bus_in   = 2'b01;
        applyStimulus();
        assertCount++;
        if (busy !== 1'b0 || mem_address !== 22'h000077) begin failCount++; $display("[TB] FAIL zero_len_load: got %b/%h expected 0/%h", busy, mem_address, 22'h000077); end
        bus_in    = 2'b00;
        burst_len = 8'd5;
        applyStimulus();
        idleInputs();
        assertCount++;
        if (busy !== 1'b1 || mem_address !== 22'h000077) begin failCount++; $display("[TB] FAIL cur_start: got %b/%h expected 1/%h", busy, mem_address, 22'h000077); end
        mem_ack = 1'b1;
        applyStimulus();
        applyStimulus();
        assertCount++;
        if (mem_address !== 22'h000079) begin failCount++; $display("[TB] FAIL mid_addr: got %h expected %h", mem_address, 22'h000079); end
        rst = 1'b1;
        applyStimulus();
        assertCount++;
        if (mem_address !== 22'h0 || busy !== 1'b0 || mem_valid !== 1'b0 || burst_done !== 1'b0) begin
            failCount++; $display("[TB] FAIL mid_reset: got addr=%h busy=%b valid=%b done=%b expected 0", mem_address, busy, mem_valid, burst_done);
        end
        rst = 1'b0;
        applyStimulus();
        applyStimulus();
        mem_ack = 1'b0;
        assertCount++;
        if (busy !== 1'b0 || burst_done !== 1'b0 || mem_address !== 22'h0) begin
            failCount++; $display("[TB] FAIL post_reset: got busy=%b done=%b addr=%h expected 0/0/0", busy, burst_done, mem_address);
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_burst();
        test_stall();
        test_ignore_busy();
        test_abort_wrap();
        test_zero_and_reset();
        assertCount++;
        if (expQ.size() != 0) begin failCount++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQ.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/mem_addr_burst_reg.md
Name: mem_addr_burst_reg

Overview:
- Parametrised successor to the two-bus memory address register.
- Loads the memory address from one of NUM_BUS internal buses using fixed priority; the lowest-index bus wins.
- Adds an auto-increment burst mode: the address steps by STRIDE on each memory acknowledge for a programmed length, with busy and done status.
- Sits between the datapath buses and the memory address port.

Parameters:
- ADDR_W, 22, address width in bits.
- NUM_BUS, 2, number of bus load sources (minimum 1).
- LEN_W, 8, burst length counter width.
- STRIDE, 1, address increment per acknowledged beat; added modulo 2^ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_data  input  NUM_BUS*ADDR_W  bus address values; bus i occupies bits [i*ADDR_W +: ADDR_W].
- bus_in  input  NUM_BUS  per-bus load strobes.
- burst_start  input  1  begin a burst; sampled only in IDLE.
- burst_len  input  LEN_W  number of beats; sampled together with burst_start.
- burst_abort  input  1  terminate an active burst.
- mem_ack  input  1  memory accepted the current address (a beat).
- mem_address  output  ADDR_W  registered address to memory.
- mem_valid  output  1  high while in BURST.
- busy  output  1  high while in BURST.
- burst_done  output  1  one-cycle pulse when the final beat is acknowledged.
- addr_ovf  output  1  sticky overflow flag; see Optional Feature.

Behaviour:
- Reset (rst=1 at a clock edge):
  - mem_address=0, mem_valid=0, busy=0, burst_done=0, addr_ovf=0.
  - State=IDLE, remaining count=0.
  - rst overrides all other inputs, including mid-burst.
- State IDLE:
  - Any bus_in bit set: mem_address <= bus_data of the lowest set index, on the next edge (1-cycle latency).
  - burst_start=1 with burst_len!=0:
    - Move to BURST; remaining <= burst_len.
    - Start address is the bus value loaded in the same cycle, if any; otherwise the current mem_address.
  - burst_start=1 with burst_len=0: ignored, stay IDLE, no burst_done. A simultaneous bus load still occurs.
  - mem_ack and burst_abort are ignored.
- State BURST:
  - mem_valid=1, busy=1. bus_in and burst_start are ignored (no load, no restart).
  - On mem_ack:
    - mem_address <= mem_address + STRIDE, truncated to ADDR_W bits (wraps).
    - remaining <= remaining - 1.
  - When mem_ack arrives with remaining=1:
    - Next state IDLE, mem_valid=0, busy=0.
    - burst_done=1 for exactly one cycle.
    - mem_address holds start + burst_len*STRIDE (mod 2^ADDR_W), which allows chained bursts.
  - burst_abort=1: IDLE on the next edge with no burst_done. The address is not incremented in that cycle, even if mem_ack is also high. Abort has priority over ack.
- burst_done is 0 in all other cycles.
- No combinational paths from any input to any output.

Optional Feature:
- Macro: MEM_ADDR_OVF_DETECT_EN.
- Defined:
  - addr_ovf is set when a burst increment carries out of bit ADDR_W-1.
  - Sticky; cleared by rst, by any bus load, or by a new burst_start.
  - Increment still wraps.
- Undefined: addr_ovf is tied to 0 and no carry logic is synthesised.

Decomposition:
- Package mem_addr_pkg:
  - State enum: IDLE=1'b0, BURST=1'b1.
  - Default constants: ADDR_W_DEF=22, LEN_W_DEF=8.
  - Function for the priority-encoder index width, clog2(NUM_BUS) with a minimum of 1.
- One sub-module, burst_len_counter: LEN_W down-counter with load, decrement, and last (remaining==1) output.
- Bus priority select stays inline.

Test Plan:
- Reset, then priority: rst=1 -> all outputs 0. Next, bus_in=2'b11, bus0=22'h00_1234, bus1=22'h3F_FFFF -> mem_address=22'h00_1234 after one edge.
- Load plus burst: bus_in=2'b10, bus1=22'h000100, burst_start=1, burst_len=4; mem_ack every cycle -> addresses 0x100, 0x101, 0x102, 0x103. burst_done pulses on the 4th ack; final mem_address=0x104; busy low afterwards.
- Stalled acks: burst_len=3 from 0x20, STRIDE=1, acks on cycles 1, 4, 5 only -> address holds between acks; burst_done pulses once, at cycle 5.
- Loads ignored while busy: during a burst, bus_in=2'b01 with bus0=0x3FFF00 and burst_start=1 -> no effect; the burst completes normally.
- Abort and wrap: start at 22'h3F_FFFE, len=4; two acks -> address wraps to 0; burst_abort plus mem_ack in the same cycle -> IDLE, address stays 0, no burst_done. With MEM_ADDR_OVF_DETECT_EN defined, addr_ovf=1 and stays 1 until the next bus load.
- Zero length and reset mid-burst: burst_start with burst_len=0 -> stays IDLE. Start a len=5 burst, assert rst after 2 acks -> mem_address=0, busy=0, no burst_done.
